// File: rtl/oci_dct_trace_ctrl.sv
// Packs 2-bit compressed trace symbols into 30-bit words and writes them to trace RAM.
// A word is presented on tw_valid on the same edge as its completing symbol or flush (0 cycles).
// One-entry output register: a full buffer waits at count 15 and later symbols are dropped.
module oci_dct_trace_ctrl #(
  parameter int ADDR_W  = 7,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_on,
  input  logic              sym_valid,
  input  logic [1:0]        sym,
  input  logic              flush,
  input  logic              test_ending,
  output logic [29:0]       dct_buffer,
  output logic [3:0]        dct_count,
  output logic              tw_valid,
  output logic [33:0]       tw_data,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic              tw_ready,
  output logic              trc_wrap,
  output logic              mem_full,
  output logic              sym_dropped,
  output logic              test_has_ended
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t      state;
  logic        flush_pend;

  logic        out_free;
  logic        hs;
  logic        addr_max;
  logic        full_stop;
  logic        accept;
  logic [29:0] buf_n;
  logic [3:0]  cnt_n;
  logic        trc_fall;
  logic        enter_drain;
  logic        flush_req;
  logic        pend_n;
  logic        push;

  // Next-buffer view after this cycle's symbol, and whether a word leaves this edge
  always_comb begin
    out_free    = !tw_valid || tw_ready;
    hs          = tw_valid && tw_ready;
    addr_max    = (tw_addr == ADDR_MAX);
    // Last slot written with wrapping disabled: nothing else may be loaded behind it
    full_stop   = hs && addr_max && !WRAP_EN;
    accept      = (state == RUN) && sym_valid && !mem_full && (dct_count != 4'd15);
    buf_n       = dct_buffer;
    cnt_n       = dct_count;
    if (accept) begin
      buf_n = {sym, dct_buffer[29:2]};
      cnt_n = dct_count + 4'd1;
    end
    enter_drain = test_ending && ((state == IDLE) || (state == RUN));
    trc_fall    = (state == RUN) && !trc_on && !test_ending;
    flush_req   = flush || enter_drain || trc_fall;
    // A flush request against an empty buffer leaves nothing pending
    pend_n      = (flush_pend || flush_req) && (cnt_n != 4'd0);
    push        = out_free && !mem_full && !full_stop && ((cnt_n == 4'd15) || pend_n);
  end

  // A symbol arriving on a full, stalled buffer is lost; flag it in the same cycle
  assign sym_dropped = (state == RUN) && sym_valid && !mem_full && (dct_count == 4'd15);

  // Control FSM; test_ending takes priority over trace-enable changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_drain) begin
            state <= DRAIN;
          end else if (trc_on && !flush_pend) begin
            // Do not resume packing until the previous partial word has left
            state <= RUN;
          end
        end
        RUN: begin
          if (test_ending) begin
            state <= DRAIN;
          end else if (!trc_on) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if ((dct_count == 4'd0) && !tw_valid && !flush_pend) begin
            state          <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

  // Packing shift register, symbol count and pending-flush flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
    end else if (mem_full || push) begin
      // Once memory is full any leftover content is discarded
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
    end else begin
      dct_buffer <= buf_n;
      dct_count  <= cnt_n;
      flush_pend <= pend_n;
    end
  end

  // Output entry: loads a word when free, clears on handshake, otherwise holds stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tw_valid <= 1'b0;
      tw_data  <= '0;
    end else if (push) begin
      tw_valid <= 1'b1;
      tw_data  <= {cnt_n, buf_n};
    end else if (hs) begin
      tw_valid <= 1'b0;
    end
  end

  // RAM address pointer advances once per accepted write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tw_addr  <= '0;
      trc_wrap <= 1'b0;
      mem_full <= 1'b0;
    end else if (hs) begin
      if (!addr_max) begin
        tw_addr <= tw_addr + ADDR_W'(1);
      end else if (WRAP_EN) begin
        tw_addr  <= '0;
        trc_wrap <= 1'b1;
      end else begin
        mem_full <= 1'b1;
      end
    end
  end

endmodule
